spi_frame_decoder: RTL

- Protocol layer that sits directly downstream of the SPI pins and beside the SPI slave shifter. Runs in the SPI sample-clock domain.
- Deserialises MOSI into LEN+1-bit words, MSB first.
- Treats the first word of each CSn-low frame as a header: one R/W bit plus an address.
- Issues register write and read-prefetch requests with an auto-incrementing address. Requests cross to the system clock via toggle signals.

---
 rtl/spi_frame_pkg.sv | 22 ++
 rtl/spi_frame_decoder_deser.sv | 38 +++
 rtl/spi_frame_decoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame decoder.
// Holds the frame FSM encoding, word-size limits and the header R/W polarity.
// No logic of its own apart from the effective-length helper.
package spi_frame_pkg;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    WR  = 2'd1,
    RD  = 2'd2
  } state_t;

  localparam int   SPI_WORD_MAX    = 16;
  localparam int   LEN_MIN         = 7;
  localparam logic HDR_RW_IS_WRITE = 1'b1;

  // Word lengths below 8 bits are not supported; clamp them up to 8.
  function automatic logic [3:0] eff_len(input logic [3:0] len);
    if (len < 4'(LEN_MIN)) return 4'(LEN_MIN);
    return len;
  endfunction

endpackage

// File: rtl/spi_frame_decoder_deser.sv
// MOSI deserialiser: shifts MSB-first bits and flags each completed word.
// Latency: word_done/word are combinational on the completing sample edge.
// No backpressure: every sample edge with the frame open consumes one bit.
import spi_frame_pkg::*;

module spi_bit_deser (
  input  logic        sclk_sample,
  input  logic        frst_n,
  input  logic [3:0]  len,
  input  logic        mosi,
  output logic        word_done,
  output logic [15:0] word,
  output logic        bits_pending
);

  logic [14:0] sr;
  logic [3:0]  bitcnt;
  logic [15:0] full;
  logic [15:0] mask;

  assign full         = {sr, mosi};
  assign mask         = 16'hFFFF >> (4'd15 - len);
  assign word_done    = (bitcnt == len);
  assign word         = full & mask;
  assign bits_pending = (bitcnt != 4'd0);

  // Shift in one bit per sample edge; bit counter wraps at the word boundary.
  always_ff @(posedge sclk_sample or negedge frst_n) begin
    if (!frst_n) begin
      sr     <= '0;
      bitcnt <= '0;
    end else begin
      sr     <= full[14:0];
      bitcnt <= word_done ? 4'd0 : bitcnt + 4'd1;
    end
  end

endmodule

// File: rtl/spi_frame_decoder.sv
// SPI frame decoder: header word selects R/W and start address, then issues
// write / read-prefetch requests as toggles with an auto-incrementing address.
// Latency: outputs update on the completing sample edge; no backpressure, the
// system side must absorb one request per word (>= 8 SCLK periods apart).
import spi_frame_pkg::*;

module spi_frame_decoder #(
  parameter int ADDR_W = 6  // must be <= 7 so the address fits below the R/W bit
) (
  input  logic              rstn,
  input  logic              sclk_sample,
  input  logic              i_CSn,
  input  logic              i_MOSI,
  input  logic [3:0]        LEN,
  output logic              o_wr_tgl,
  output logic              o_rd_tgl,
  output logic [ADDR_W-1:0] o_addr,
  output logic [15:0]       o_wdata,
  output logic              o_busy,
  output logic [7:0]        o_word_cnt,
  output logic              o_wrap_err
);

  logic              frst_n;
  logic [3:0]        len_eff;
  logic              word_done;
  logic [15:0]       word;
  logic              bits_pending;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] hdr_addr;
  logic              issue_wr, issue_rd, load_hdr;

  // CSn high closes the frame asynchronously, same as a full reset for framing.
  assign frst_n  = rstn & ~i_CSn;
  assign len_eff = eff_len(LEN);

  spi_bit_deser u_deser (
    .sclk_sample  (sclk_sample),
    .frst_n       (frst_n),
    .len          (len_eff),
    .mosi         (i_MOSI),
    .word_done    (word_done),
    .word         (word),
    .bits_pending (bits_pending)
  );

  assign hdr_addr = word[ADDR_W-1:0];
  assign o_busy   = (state_q != HDR) | bits_pending;

  // Frame state register, cleared at every frame boundary.
  always_ff @(posedge sclk_sample or negedge frst_n) begin
    if (!frst_n) state_q <= HDR;
    else         state_q <= state_d;
  end

  // Next state and request decode for the completed word.
  always_comb begin
    state_d  = state_q;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    load_hdr = 1'b0;
    req_addr = cur_addr;
    case (state_q)
      HDR: if (word_done) begin
        if (word[len_eff] == HDR_RW_IS_WRITE) begin
          state_d  = WR;
          load_hdr = 1'b1;
        end else begin
          state_d  = RD;
          issue_rd = 1'b1;
          req_addr = hdr_addr;
        end
      end
      WR: if (word_done) issue_wr = 1'b1;
      RD: if (word_done) issue_rd = 1'b1;
      default: state_d = HDR;
    endcase
  end

  // Request outputs and address counter; these survive frame boundaries.
  always_ff @(posedge sclk_sample or negedge rstn) begin
    if (!rstn) begin
      o_wr_tgl   <= 1'b0;
      o_rd_tgl   <= 1'b0;
      o_addr     <= '0;
      o_wdata    <= '0;
      o_wrap_err <= 1'b0;
      cur_addr   <= '0;
    end else if (!i_CSn) begin
      if (issue_wr || issue_rd) begin
        o_addr   <= req_addr;
        cur_addr <= req_addr + ADDR_W'(1);
        if (&req_addr) o_wrap_err <= 1'b1;
      end else if (load_hdr) begin
        cur_addr <= hdr_addr;
      end
      if (issue_wr) begin
        o_wdata  <= word;
        o_wr_tgl <= ~o_wr_tgl;
      end
      if (issue_rd) o_rd_tgl <= ~o_rd_tgl;
    end
  end

  // Completed-word counter for the current frame, saturating at 255.
  always_ff @(posedge sclk_sample or negedge frst_n) begin
    if (!frst_n)                                o_word_cnt <= '0;
    else if (word_done && o_word_cnt != 8'hFF) o_word_cnt <= o_word_cnt + 8'd1;
  end

endmodule
